axis_pkt_arbiter: RTL

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_arb_pkg.sv | 8 +
 rtl/axis_skid_buffer.sv | 38 +++
 rtl/axis_pkt_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared enums and helpers for the AXI-Stream packet arbiter
package axis_arb_pkg;
  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
  typedef enum logic {IDLE, PKT} arb_state_e;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered buffer decoupling input ready from output ready
module axis_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         push, pop;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // storage, pointers and occupancy; ready comes only from the registered count
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked N:1 AXI-Stream arbiter with round-robin or fixed priority
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int        NUM_CHANNELS = 4,
  parameter int        DATA_W       = 32,
  parameter int        ID_W         = 4,
  parameter arb_mode_e MODE         = ARB_RR,
  localparam int       CHANNELS_W   = chan_w(NUM_CHANNELS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CHANNELS-1:0]      ch_enable_i,
  input  logic [NUM_CHANNELS-1:0]      s_tvalid_i,
  output logic [NUM_CHANNELS-1:0]      s_tready_o,
  input  logic [NUM_CHANNELS*DATA_W-1:0] s_tdata_i,
  input  logic [NUM_CHANNELS-1:0]      s_tlast_i,
  input  logic [NUM_CHANNELS*ID_W-1:0] s_tid_i,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [DATA_W-1:0]            m_tdata_o,
  output logic                         m_tlast_o,
  output logic [ID_W-1:0]              m_tid_o,
  output logic [CHANNELS_W-1:0]        grant_idx_o,
  output logic                         busy_o
);
  localparam int PW = DATA_W + ID_W + 1;
  arb_state_e              state, state_d;
  logic [CHANNELS_W-1:0]   rr_ptr, rr_d, grant_d, winner;
  logic [CHANNELS_W:0]     idx;
  logic                    found;
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    in_valid, in_ready, accept, in_last;
  logic [PW-1:0]           in_payload, out_payload;
  assign eligible   = s_tvalid_i & ch_enable_i;
  assign busy_o     = state == PKT;
  assign in_valid   = busy_o && s_tvalid_i[grant_idx_o];
  assign accept     = in_valid && in_ready;
  assign in_last    = s_tlast_i[grant_idx_o];
  assign in_payload = {in_last, s_tid_i[grant_idx_o*ID_W +: ID_W], s_tdata_i[grant_idx_o*DATA_W +: DATA_W]};
  assign s_tready_o = busy_o ? (NUM_CHANNELS'(in_ready) << grant_idx_o) : '0;
  assign {m_tlast_o, m_tid_o, m_tdata_o} = out_payload;
  // winner search: rotate from rr_ptr in round-robin, from channel 0 in fixed priority
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = (CHANNELS_W+1)'(i) + ((MODE == ARB_RR) ? {1'b0, rr_ptr} : '0);
      if (idx >= (CHANNELS_W+1)'(NUM_CHANNELS)) idx = idx - (CHANNELS_W+1)'(NUM_CHANNELS);
      if (!found && eligible[idx[CHANNELS_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[CHANNELS_W-1:0];
      end
    end
  end
  // next state: lock a winner in IDLE, release after the granted channel's last beat is taken
  always_comb begin
    state_d = state;
    grant_d = grant_idx_o;
    rr_d    = rr_ptr;
    if (state == IDLE) begin
      if (found) begin
        state_d = PKT;
        grant_d = winner;
      end
    end else if (accept && in_last) begin
      state_d = IDLE;
      rr_d    = (grant_idx_o == CHANNELS_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end
  // state, grant and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant_idx_o <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_d;
      grant_idx_o <= grant_d;
      rr_ptr      <= rr_d;
    end
  end
  axis_skid_buffer #(.W(PW)) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(m_tvalid_o),
    .out_ready(m_tready_i),
    .out_data (out_payload)
  );
endmodule
